// File: rtl/velocity_cell_stream_ctrl.sv
// Velocity cell RAM sequencer: reads the particle count at address 0, then streams
// words 1..N to the motion-update unit through a 2-entry FIFO while granting write-backs.
module velocity_cell_stream_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_num,
    output logic                  cnt_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [2:0]            state_dbg
);

    // Handshake: a word transfers on a rising edge where out_valid && out_ready are both 1;
    // out_valid/out_data/out_pid hold steady until then. wb_valid is always accepted (wb_ready=1).

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_CNT   = 3'd1,
        S_WAIT_CNT = 3'd2,
        S_STREAM   = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_pid;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH-1:0] e0_data, e1_data;
    logic [ADDR_WIDTH-1:0] e0_pid, e1_pid;

    logic                  pop;
    logic                  credit_ok;
    logic                  issue_cnt;
    logic                  issue_stream;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH-1:0] cnt_val;

    assign state_dbg = state;
    assign busy      = (state == S_RD_CNT) || (state == S_WAIT_CNT) ||
                       (state == S_STREAM) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign wb_ready  = !rst;
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = e0_data;
    assign out_pid   = e0_pid;
    assign pop       = out_valid && out_ready;
    assign cnt_val   = mem_q[ADDR_WIDTH-1:0];

    // Occupancy counts the word leaving this cycle as freed, which keeps a
    // ready consumer fed every cycle without ever exceeding two entries.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    assign credit_ok = occupancy < (3'd2 + {2'b00, pop});

    always_comb begin
        mem_wren     = 1'b0;
        mem_rden     = 1'b0;
        mem_address  = '0;
        mem_data     = '0;
        issue_cnt    = 1'b0;
        issue_stream = 1'b0;
        if (rst) begin
            mem_wren = 1'b0;
        end else if (wb_valid) begin
            mem_wren    = 1'b1;
            mem_address = wb_addr;
            mem_data    = wb_data;
        end else if (state == S_RD_CNT) begin
            mem_rden  = 1'b1;
            issue_cnt = 1'b1;
        end else if (state == S_STREAM && credit_ok) begin
            mem_rden     = 1'b1;
            mem_address  = next_addr;
            issue_stream = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            particle_num <= '0;
            cnt_err      <= 1'b0;
            next_addr    <= ADDR_WIDTH'(1);
            inflight     <= 1'b0;
            inflight_pid <= '0;
            fifo_count   <= 2'd0;
            e0_data      <= '0;
            e1_data      <= '0;
            e0_pid       <= '0;
            e1_pid       <= '0;
        end else begin
            inflight <= issue_stream;
            if (issue_stream) inflight_pid <= next_addr;

            // The word read last cycle is on mem_q now and enters the FIFO.
            if (inflight && pop) begin
                if (fifo_count == 2'd1) begin
                    e0_data <= mem_q;
                    e0_pid  <= inflight_pid;
                end else begin
                    e0_data <= e1_data;
                    e0_pid  <= e1_pid;
                    e1_data <= mem_q;
                    e1_pid  <= inflight_pid;
                end
            end else if (inflight) begin
                if (fifo_count == 2'd0) begin
                    e0_data <= mem_q;
                    e0_pid  <= inflight_pid;
                end else begin
                    e1_data <= mem_q;
                    e1_pid  <= inflight_pid;
                end
                fifo_count <= fifo_count + 2'd1;
            end else if (pop) begin
                e0_data    <= e1_data;
                e0_pid     <= e1_pid;
                fifo_count <= fifo_count - 2'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_RD_CNT;
                        cnt_err      <= 1'b0;
                        particle_num <= '0;
                        next_addr    <= ADDR_WIDTH'(1);
                    end
                end
                S_RD_CNT: begin
                    if (issue_cnt) state <= S_WAIT_CNT;
                end
                S_WAIT_CNT: begin
                    if (cnt_val > MAX_CNT) begin
                        particle_num <= MAX_CNT;
                        cnt_err      <= 1'b1;
                        state        <= S_STREAM;
                    end else begin
                        particle_num <= cnt_val;
                        state        <= (cnt_val == '0) ? S_DONE : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (issue_stream) begin
                        next_addr <= next_addr + ADDR_WIDTH'(1);
                        if (next_addr == particle_num) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_velocity_cell_stream_ctrl.sv
// Directed bench for velocity_cell_stream_ctrl: behavioural single-port RAM with
// 1-cycle read latency, scan runner task, and immediate-assertion checks.
module tb_velocity_cell_stream_ctrl;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, cnt_err;
    logic [AW-1:0] particle_num;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_pid;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden, mem_wren;
    logic [DW-1:0] mem_q;
    logic [2:0]    state_dbg;

    int checks = 0;
    int failures = 0;

    // RAM model: addr 0 comes from ram0; other words default to vel(addr)
    // unless written during the current test generation.
    logic [DW-1:0] ram [0:255];
    int            ram_gen [0:255];
    int            gen = 1;
    logic [DW-1:0] ram0 = '0;

    logic [AW-1:0] got_pid[$];
    logic [DW-1:0] got_data[$];
    int            done_iter, done_cnt, hs_first, hs_last;
    logic          busy_at1;

    velocity_cell_stream_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .particle_num(particle_num), .cnt_err(cnt_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pid(out_pid),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_q(mem_q), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] vel(input int k);
        return {32'(k * 7 + 1), 32'(k ^ 32'h5a), 32'(k + 32'h3f00)};
    endfunction

    always @(posedge clk) begin
        if (mem_wren) begin
            ram[mem_address]     <= mem_data;
            ram_gen[mem_address] <= gen;
        end
        if (mem_rden) begin
            if (mem_address == '0)                 mem_q <= ram0;
            else if (ram_gen[mem_address] == gen)  mem_q <= ram[mem_address];
            else                                   mem_q <= vel(int'(mem_address));
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One scan: start at iteration 0, sample each cycle at negedge+1.
    // rst_after>0 stops after that many words have been handshaken.
    task automatic run_scan(input int cnt, input bit rnd, input bit wb_on, input int rst_after);
        ram0 = DW'(cnt);
        gen++;
        got_pid.delete();
        got_data.delete();
        done_iter = -1; done_cnt = 0; hs_first = -1; hs_last = -1; busy_at1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start     = (i == 0);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wb_on && i < 8 && (i % 2) == 0) begin
                wb_valid = 1'b1; wb_addr = AW'(6); wb_data = 96'hA5;
            end else begin
                wb_valid = 1'b0;
            end
            #1;
            if (i == 1) busy_at1 = busy;
            if (out_valid && out_ready) begin
                got_pid.push_back(out_pid);
                got_data.push_back(out_data);
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (done) begin
                done_cnt++;
                if (done_iter < 0) done_iter = i;
            end
            if (rst_after > 0 && got_pid.size() == rst_after) break;
            if (done_iter >= 0 && i > done_iter + 2) break;
        end
        start = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int n, input int wb_pid, input logic [DW-1:0] wb_val);
        chk({tag, "_count"}, 128'(got_pid.size()), 128'(n));
        for (int i = 0; i < got_pid.size() && i < n; i++) begin
            chk({tag, "_pid"}, 128'(got_pid[i]), 128'(i + 1));
            chk({tag, "_data"}, 128'(got_data[i]), (i + 1 == wb_pid) ? 128'(wb_val) : 128'(vel(i + 1)));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_rden"}, 128'(mem_rden), 128'(0));
        chk({tag, "_wren"}, 128'(mem_wren), 128'(0));
        chk({tag, "_cnt_err"}, 128'(cnt_err), 128'(0));
        chk({tag, "_pnum"}, 128'(particle_num), 128'(0));
        chk({tag, "_state"}, 128'(state_dbg), 128'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("rst");
        chk("rst_wb_ready", 128'(wb_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("wb_ready_run", 128'(wb_ready), 128'(1));

        // T1: five particles, ready always high
        run_scan(5, 1'b0, 1'b0, 0);
        chk("t1_busy", 128'(busy_at1), 128'(1));
        chk("t1_done_seen", 128'(done_iter >= 0), 128'(1));
        chk("t1_done_once", 128'(done_cnt), 128'(1));
        chk("t1_first_hs", 128'(hs_first), 128'(5));
        chk("t1_back2back", 128'(hs_last - hs_first), 128'(4));
        chk("t1_done_lat", 128'(done_iter), 128'(hs_last + 1));
        chk("t1_pnum", 128'(particle_num), 128'(5));
        chk("t1_cnt_err", 128'(cnt_err), 128'(0));
        check_stream("t1", 5, 0, '0);

        // T3: oversized count clamps to 219
        run_scan(250, 1'b0, 1'b0, 0);
        chk("t3_done_seen", 128'(done_iter >= 0), 128'(1));
        chk("t3_pnum", 128'(particle_num), 128'(219));
        chk("t3_cnt_err", 128'(cnt_err), 128'(1));
        check_stream("t3", 219, 0, '0);

        // T2: empty cell; also confirms start clears cnt_err
        run_scan(0, 1'b0, 1'b0, 0);
        chk("t2_done_seen", 128'(done_iter >= 0), 128'(1));
        chk("t2_done_once", 128'(done_cnt), 128'(1));
        chk("t2_count", 128'(got_pid.size()), 128'(0));
        chk("t2_pnum", 128'(particle_num), 128'(0));
        chk("t2_cnt_err", 128'(cnt_err), 128'(0));

        // T4: random backpressure
        run_scan(8, 1'b1, 1'b0, 0);
        chk("t4_done_seen", 128'(done_iter >= 0), 128'(1));
        chk("t4_done_once", 128'(done_cnt), 128'(1));
        check_stream("t4", 8, 0, '0);

        // T5: write-backs to pid 6 interleaved from the start cycle on
        run_scan(8, 1'b0, 1'b1, 0);
        chk("t5_done_seen", 128'(done_iter >= 0), 128'(1));
        check_stream("t5", 8, 6, 96'hA5);

        // T6: reset mid-stream after pid 2, then a clean rescan
        run_scan(250, 1'b0, 1'b0, 2);
        chk("t6_reached", 128'(got_pid.size()), 128'(2));
        chk("t6_pre_err", 128'(cnt_err), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_vals("t6_rst");
        rst = 1'b0;
        run_scan(5, 1'b0, 1'b0, 0);
        chk("t6_done_seen", 128'(done_iter >= 0), 128'(1));
        check_stream("t6_rescan", 5, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
